ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port RAM with registered read data.
// Pops own the RAM port when both requests arrive; the push source holds its data.
module ram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  output logic          ram_wr_rd_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_valid_q, pop_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          pop_acc, push_acc;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Gating with rst keeps the RAM quiet and blocks accepts while in reset.
  assign pop_acc    = rst && pop && !empty && !clear;
  assign push_ready = rst && !full && !pop_acc && !clear;
  assign push_acc   = push && push_ready;

  assign ram_wr_rd_en = push_acc;
  assign ram_addr     = push_acc ? wr_ptr_q : rd_ptr_q;
  assign ram_data_in  = push_data;

  assign pop_data  = ram_data_out;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_acc;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pop_valid_d = 1'b0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      // A push losing to a pop is only deferred, so it is not an overflow.
      if (push && full && !pop_acc) ovf_d = 1'b1;
      if (pop && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, queue-based reference, directed plus random traffic.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          push;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;
  logic          ram_wr_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf),
    .ram_wr_rd_en(ram_wr_rd_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Single-port RAM with registered read, reset active-high from !rst.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk or negedge rst) begin
    if (!rst) ram_data_out <= '0;
    else if (ram_wr_rd_en) mem[ram_addr] <= ram_data_in;
    else ram_data_out <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents as a queue, write/read slots as counts since clear.
  logic [DW-1:0] q [$];
  bit            m_ovf, m_udf, m_valid;
  logic [DW-1:0] m_data;
  int            wr_idx, rd_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_valid = 0;
    wr_idx = 0; rd_idx = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
    chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".pop_data"}, 32'(pop_data), 32'(m_data));
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit r, input bit c);
    int  cnt;
    bit  racc, rdy, pacc;
    push = p; push_data = d; pop = r; clear = c;
    cnt  = q.size();
    racc = r && (cnt != 0) && !c;
    rdy  = (cnt != DEPTH) && !racc && !c;
    pacc = p && rdy;
    #1;
    chk("push_ready", 32'(push_ready), 32'(rdy));
    chk("ram_wr_rd_en", 32'(ram_wr_rd_en), 32'(pacc));
    chk("ram_addr", 32'(ram_addr), 32'(pacc ? (wr_idx % DEPTH) : (rd_idx % DEPTH)));
    chk("ram_data_in", 32'(ram_data_in), 32'(d));
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (pacc) begin
        q.push_back(d);
        wr_idx++;
      end
      if (racc) begin
        m_data = q.pop_front();
        rd_idx++;
      end
      if (p && cnt == DEPTH && !racc) m_ovf = 1;
      if (r && cnt == 0) m_udf = 1;
      m_valid = racc;
    end
    #1;
    check_state("post");
    $display("txn push=%0b data=%02h pop=%0b clr=%0b -> count=%0d valid=%0b pop_data=%02h ovf=%0b udf=%0b",
             p, d, r, c, count, pop_valid, pop_data, ovf, udf);
    push = 0; pop = 0; clear = 0;
  endtask

  initial begin
    rst = 1'b0; clear = 0; push = 0; pop = 0; push_data = '0;
    model_reset();
    #12;
    check_state("reset");
    chk("reset.push_ready", 32'(push_ready), 32'(0));
    chk("reset.ram_wr_rd_en", 32'(ram_wr_rd_en), 32'(0));
    #11 rst = 1'b1;
    @(posedge clk); #1;

    // First push right after reset, then 0x22, 0x33 and three pops.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 8; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    chk("ovf_after_full_push", 32'(ovf), 32'(1));
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // Simultaneous push/pop with two stored entries.
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h55, 1, 0);
    step(1, 8'h55, 0, 0);
    repeat (3) step(0, 8'h00, 1, 0);

    // Wrap pointers with 13 push/pop pairs.
    for (int i = 0; i < 13; i++) begin
      step(1, 8'(8'h30 + i), 0, 0);
      step(0, 8'h00, 1, 0);
    end

    // Underflow from empty, then clear.
    step(0, 8'h00, 1, 0);
    step(1, 8'h77, 1, 0);
    step(0, 8'h00, 0, 1);

    // Mid-cycle reset with a pop in flight.
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    #2 rst = 1'b0; push = 1; push_data = 8'hEE;
    model_reset();
    #1;
    check_state("async_rst");
    chk("async_rst.push_ready", 32'(push_ready), 32'(0));
    chk("async_rst.ram_wr_rd_en", 32'(ram_wr_rd_en), 32'(0));
    @(posedge clk); #1;
    chk("rst_held.ram_wr_rd_en", 32'(ram_wr_rd_en), 32'(0));
    check_state("rst_held");
    #3 rst = 1'b1; push = 0;
    @(posedge clk); #1;
    check_state("rst_release");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
